calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports named clk and reset.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  synchronous active-high reset, highest priority.
REQ-004 SHALL have port: start  input  1  level; begins a calculation when sampled high in IDLE.
REQ-005 SHALL have port: enter  input  1  push-button; only its rising edge advances the sequence.
REQ-006 SHALL have port: sw  input  4  operand value, unsigned.
REQ-007 SHALL have port: op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 SHALL have port: state  output  3  current FSM state encoding.
REQ-009 SHALL have port: result  output  8  registered calculation result.
REQ-010 SHALL have port: neg  output  1  subtraction result negative (A<B).
REQ-011 SHALL have port: err  output  1  divide-by-zero.
REQ-012 SHALL have port: busy  output  1  high while state=EXEC.
REQ-013 SHALL have port: done  output  1  high while state=DONE.

Function
REQ-014 SHALL encode states IDLE=000, LOAD_A=001, LOAD_B=010, LOAD_OP=011, EXEC=100, DONE=101; codes 110/111 SHALL go to IDLE on the next edge.
REQ-015 SHALL detect enter edge as enter & ~enter_q, with enter_q a one-cycle registered copy of enter, cleared by reset.
REQ-016 SHALL have the following transitions: IDLE->LOAD_A when start=1. LOAD_A->LOAD_B on edge, capturing A=sw. LOAD_B->LOAD_OP on edge, capturing B=sw. LOAD_OP->EXEC on edge, capturing opc=op.
REQ-017 SHALL ignore the enter edge in IDLE and ignore start in every state except IDLE; start and edge together in IDLE: go to LOAD_A, nothing captured.
REQ-018 SHALL ignore the enter edge while in EXEC.
REQ-019 SHALL exit EXEC as follows: add/sub/mul spend exactly 1 cycle in EXEC; div spends exactly 4 cycles (restoring, one quotient bit per cycle, MSB first); then go to DONE.
REQ-020 SHALL compute add as result = {3'b0, A+B} (5-bit sum, zero-extended).
REQ-021 SHALL compute sub as result = {4'b0, |A-B|}, with neg=1 if A<B, else neg=0.
REQ-022 SHALL compute mul as result = A*B (8-bit, no overflow possible).
REQ-023 SHALL compute div as result = {remainder[3:0], quotient[3:0]}.
REQ-024 SHALL handle div with B=0 as follows: err=1, result=8'h00, EXEC lasts 1 cycle, no iteration.
REQ-025 SHALL write result, neg and err on the EXEC->DONE edge and hold them through DONE.
REQ-026 SHALL clear result, neg and err on the LOAD_A->LOAD_B edge; they SHALL not change at any other time.
REQ-027 SHALL go DONE->LOAD_A on an enter edge (new calculation, previous result still shown until the next LOAD_A->LOAD_B edge).
REQ-028 SHALL drive busy and done combinationally from state; never both high.

Reset
REQ-029 SHALL apply the following values on any clk edge with reset=1: state=000, result=8'h00, neg=0, err=0, A=B=opc=0, enter_q=0, divider registers cleared; therefore busy=0 and done=0.
REQ-030 SHALL handle reset mid-EXEC (including mid-division) by abandoning the operation: the next state is IDLE and no result is written.
REQ-031 SHALL have reset take priority over simultaneous start/enter.

Verification
REQ-032 SHALL cover: reset, start pulse, A=9, B=5, op=00 via three enter pulses -> EXEC 1 cycle, then DONE with result=8'h0E, neg=0, err=0.
REQ-033 SHALL cover: A=3, B=7, op=01 -> result=8'h04, neg=1; A=7, B=3 -> result=8'h04, neg=0.
REQ-034 SHALL cover: A=15, B=15, op=10 -> result=8'hE1; A=13, B=4, op=11 -> busy high exactly 4 cycles, result=8'h13.
REQ-035 SHALL cover: A=6, B=0, op=11 -> busy 1 cycle, err=1, result=8'h00.
REQ-036 SHALL cover: enter held high 5 cycles in LOAD_A -> exactly one advance to LOAD_B; enter edge during EXEC -> no effect on state or result.
REQ-037 SHALL cover: reset asserted on cycle 2 of a div EXEC -> next edge state=000, result=8'h00, busy=0, done=0.

Source files
------------

// File: rtl/calc_sequencer.sv
// Four-function 4-bit calculator sequencer: operands and opcode are entered with push-button
// edges, then the result is computed (restoring division takes four cycles) and held in DONE.
module calc_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       enter,
   input  logic [3:0] sw,
   input  logic [1:0] op,
   output logic [2:0] state,
   output logic [7:0] result,
   output logic       neg,
   output logic       err,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      LOAD_A  = 3'b001,
      LOAD_B  = 3'b010,
      LOAD_OP = 3'b011,
      EXEC    = 3'b100,
      DONE    = 3'b101
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } opcode_t;

   state_t     state_q, state_d;
   logic       enter_q;
   logic       enter_edge;
   logic [3:0] a_q, b_q;
   opcode_t    opc_q;

   // Restoring divider: rem_q is the partial remainder, quo_q shifts the dividend out / quotient in.
   logic [3:0] rem_q, quo_q;
   logic [1:0] cnt_q;
   logic [4:0] shifted, diff;
   logic       take;
   logic [3:0] rem_nx, quo_nx;

   logic       exec_last;
   logic [7:0] calc_res;
   logic       calc_neg, calc_err;

   assign enter_edge = enter & ~enter_q;

   always_comb begin
      shifted = {rem_q, quo_q[3]};
      diff    = shifted - {1'b0, b_q};
      take    = (shifted >= {1'b0, b_q});
      rem_nx  = take ? diff[3:0] : shifted[3:0];
      quo_nx  = {quo_q[2:0], take};
   end

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      calc_res  = 8'h00;
      calc_neg  = 1'b0;
      calc_err  = 1'b0;
      exec_last = 1'b1;
      case (opc_q)
         OP_ADD: calc_res = {3'b000, ({1'b0, a_q} + {1'b0, b_q})};
         OP_SUB: begin
            if (a_q < b_q) begin
               calc_res = {4'b0000, (b_q - a_q)};
               calc_neg = 1'b1;
            end else begin
               calc_res = {4'b0000, (a_q - b_q)};
            end
         end
         OP_MUL: calc_res = {4'b0000, a_q} * {4'b0000, b_q};
         OP_DIV: begin
            if (b_q == 4'd0) begin
               calc_err = 1'b1;
            end else begin
               exec_last = (cnt_q == 2'd3);
               calc_res  = {rem_nx, quo_nx};
            end
         end
         default: calc_res = 8'h00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)      state_d = LOAD_A;
         LOAD_A:  if (enter_edge) state_d = LOAD_B;
         LOAD_B:  if (enter_edge) state_d = LOAD_OP;
         LOAD_OP: if (enter_edge) state_d = EXEC;
         EXEC:    if (exec_last)  state_d = DONE;
         DONE:    if (enter_edge) state_d = LOAD_A;
         default:                 state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so only clk is in the list.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         enter_q <= 1'b0;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         opc_q   <= OP_ADD;
         rem_q   <= 4'd0;
         quo_q   <= 4'd0;
         cnt_q   <= 2'd0;
         result  <= 8'h00;
         neg     <= 1'b0;
         err     <= 1'b0;
      end else begin
         enter_q <= enter;
         if (state_q == LOAD_A && enter_edge) begin
            a_q    <= sw;
            result <= 8'h00;
            neg    <= 1'b0;
            err    <= 1'b0;
         end
         if (state_q == LOAD_B && enter_edge) b_q <= sw;
         if (state_q == LOAD_OP && enter_edge) begin
            opc_q <= opcode_t'(op);
            rem_q <= 4'd0;
            quo_q <= a_q;
            cnt_q <= 2'd0;
         end
         if (state_q == EXEC) begin
            if (opc_q == OP_DIV) begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt_q <= cnt_q + 2'd1;
            end
            if (exec_last) begin
               result <= calc_res;
               neg    <= calc_neg;
               err    <= calc_err;
            end
         end
      end
   end

   assign state = state_q;
   assign busy  = (state_q == EXEC);
   assign done  = (state_q == DONE);

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: each calculation queues its expected outcome, and a
// monitor compares result/neg/err and EXEC length whenever done rises.
module tb_calc_sequencer;

   logic       clk = 1'b0;
   logic       reset, start, enter;
   logic [3:0] sw;
   logic [1:0] op;
   logic [2:0] state;
   logic [7:0] result;
   logic       neg, err, busy, done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] result;
      logic       neg;
      logic       err;
      int         busy_cycles;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   exp_t push_e;
   int   busy_cnt = 0;
   logic done_prev = 1'b0;
   bit   in_done = 1'b0;

   always #5 clk = ~clk;

   calc_sequencer dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .enter  (enter),
      .sw     (sw),
      .op     (op),
      .state  (state),
      .result (result),
      .neg    (neg),
      .err    (err),
      .busy   (busy),
      .done   (done)
   );

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Monitor: counts EXEC cycles and compares each completed calculation against the queue.
   always @(negedge clk) begin
      if (reset) begin
         busy_cnt  = 0;
         done_prev = 1'b0;
      end else begin
         if (busy) busy_cnt++;
         if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               mon_e = sb_q.pop_front();
               check({mon_e.name, "_result"}, result, mon_e.result);
               check({mon_e.name, "_neg"}, neg, mon_e.neg);
               check({mon_e.name, "_err"}, err, mon_e.err);
               check({mon_e.name, "_busy_cycles"}, busy_cnt, mon_e.busy_cycles);
               check({mon_e.name, "_not_busy"}, busy, 0);
            end
            busy_cnt = 0;
         end
         done_prev = done;
      end
   end

   task automatic expect_calc(input string name, input logic [7:0] r, input logic n, input logic e,
                              input int bc);
      push_e.result      = r;
      push_e.neg         = n;
      push_e.err         = e;
      push_e.busy_cycles = bc;
      push_e.name        = name;
      sb_q.push_back(push_e);
   endtask

   task automatic press(input logic [3:0] v, input logic [1:0] o);
      sw    = v;
      op    = o;
      enter = 1'b1;
      @(posedge clk); #1;
      enter = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic begin_calc();
      if (in_done) begin
         press(4'd0, 2'd0);
      end else begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_done_reached"}, done, 1);
      @(negedge clk); #1;
      in_done = 1'b1;
   endtask

   task automatic run_calc(input string name, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] o, input logic [7:0] r, input logic n,
                           input logic e, input int bc, input bit poke);
      expect_calc(name, r, n, e, bc);
      begin_calc();
      press(a, 2'd0);
      press(b, 2'd0);
      press(4'd0, o);
      if (poke) begin
         enter = 1'b1;
         @(posedge clk); #1;
         enter = 1'b0;
         check({name, "_exec_ignores_enter"}, state, 3'd4);
      end
      wait_done(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      start = 1'b1;
      enter = 1'b1;
      sw    = 4'hF;
      op    = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", state, 3'd0);
      check("reset_result", result, 8'h00);
      check("reset_neg", neg, 0);
      check("reset_err", err, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      reset = 1'b0;
      start = 1'b0;
      enter = 1'b0;
      sw    = 4'd0;
      op    = 2'd0;
      @(posedge clk); #1;
      check("idle_holds", state, 3'd0);

      run_calc("add_9_5", 4'd9, 4'd5, 2'b00, 8'h0E, 1'b0, 1'b0, 1, 1'b0);

      // DONE -> LOAD_A keeps the old result until A is captured.
      expect_calc("sub_3_7", 8'h04, 1'b1, 1'b0, 1);
      press(4'd0, 2'd0);
      check("done_to_load_a", state, 3'd1);
      check("result_held_in_load_a", result, 8'h0E);
      press(4'd3, 2'd0);
      check("load_b_state", state, 3'd2);
      check("result_cleared_on_a", result, 8'h00);
      press(4'd7, 2'd0);
      press(4'd0, 2'b01);
      wait_done("sub_3_7");

      run_calc("sub_7_3", 4'd7, 4'd3, 2'b01, 8'h04, 1'b0, 1'b0, 1, 1'b0);
      run_calc("mul_15_15", 4'd15, 4'd15, 2'b10, 8'hE1, 1'b0, 1'b0, 1, 1'b0);
      run_calc("div_13_4", 4'd13, 4'd4, 2'b11, 8'h13, 1'b0, 1'b0, 4, 1'b1);
      run_calc("div_6_0", 4'd6, 4'd0, 2'b11, 8'h00, 1'b0, 1'b1, 1, 1'b0);

      // Enter held high for five cycles in LOAD_A advances exactly once.
      expect_calc("add_2_3", 8'h05, 1'b0, 1'b0, 1);
      press(4'd0, 2'd0);
      sw    = 4'd2;
      enter = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("enter_held_one_advance", state, 3'd2);
      enter = 1'b0;
      @(posedge clk); #1;
      check("enter_release_no_advance", state, 3'd2);
      press(4'd3, 2'd0);
      press(4'd0, 2'b00);
      wait_done("add_2_3");

      // Reset during the second cycle of a division abandons it.
      begin_calc();
      press(4'd13, 2'd0);
      press(4'd4, 2'd0);
      press(4'd0, 2'b11);
      check("div_running", busy, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_div_reset_state", state, 3'd0);
      check("mid_div_reset_result", result, 8'h00);
      check("mid_div_reset_busy", busy, 0);
      check("mid_div_reset_done", done, 0);
      reset   = 1'b0;
      in_done = 1'b0;
      @(posedge clk); #1;

      run_calc("mul_3_5", 4'd3, 4'd5, 2'b10, 8'h0F, 1'b0, 1'b0, 1, 1'b0);

      @(negedge clk); #1;
      check("scoreboard_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
